// File: rtl/fibonacci_index_finder_if.sv
// Start/done handshake bundle for the Fibonacci index finder.
// The master issues start/value; the slave returns busy/done and the result.
interface fibonacci_index_finder_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] index;
    logic             is_fib;

    modport master (
        output start, value,
        input  busy, done, index, is_fib
    );

    modport slave (
        input  start, value,
        output busy, done, index, is_fib
    );
endinterface

// File: rtl/fibonacci_index_finder.sv
// Iterative search for the Fibonacci index of N, or of the largest F(k) below N.
// Outputs are registered from the FSM state, so busy/done trail the state by one cycle.
//
// state  | meaning
// IDLE   | waiting for start; result held
// SEARCH | walking a=F(k), b=F(k+1) until a >= N
// DONE   | result captured; done pulse is issued next cycle
module fibonacci_index_finder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    fibonacci_index_finder_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   b_q, b_d;
    logic [IDX_W:0]   k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             is_fib_q, is_fib_d;

    logic [WIDTH:0]   n_ext;
    logic [IDX_W:0]   k_m1;

    assign n_ext = {1'b0, n_q};
    assign k_m1  = k_q - (IDX_W+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            index_q  <= '0;
            is_fib_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            index_q  <= index_d;
            is_fib_q <= is_fib_d;
        end
    end

    // a carries one extra bit, so a >= N also catches values beyond the input range
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SEARCH;
            SEARCH:  if (a_q >= n_ext) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        n_d      = n_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        index_d  = index_q;
        is_fib_d = is_fib_q;
        busy_d   = (state_q == SEARCH);
        done_d   = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d = bus.value;
                    a_d = '0;
                    b_d = (WIDTH+1)'(1);
                    k_d = '0;
                end
            end
            SEARCH: begin
                if (a_q == n_ext) begin
                    index_d  = k_q[IDX_W-1:0];
                    is_fib_d = 1'b1;
                end else if (a_q > n_ext) begin
                    index_d  = k_m1[IDX_W-1:0];
                    is_fib_d = 1'b0;
                end else begin
                    a_d = b_q;
                    b_d = a_q + b_q;
                    k_d = k_q + (IDX_W+1)'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.index  = index_q;
    assign bus.is_fib = is_fib_q;
endmodule
